// File: rtl/mult_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
package mult_pkg;

    localparam int unsigned MULT_W = 16;
    localparam int unsigned PROD_W = 2 * MULT_W;

    // 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Round-robin pick between two requesters; bit 0 = requester 0, bit 1 = requester 1.
    function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (v0 && v1) begin
            g = last ? 2'b01 : 2'b10;
        end else if (v0) begin
            g = 2'b01;
        end else if (v1) begin
            g = 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/simple_combinational_mult.sv
// Unsigned 16x16 -> 32 combinational multiplier.
module simple_combinational_mult
    import mult_pkg::*;
(
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    // Full-width product, operands zero-extended before the multiply.
    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one multiplier between two valid/ready requesters.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_product,
    input  logic               rsp_ready,
    output logic               busy,
    output logic [15:0]        op_count
);

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               id_r;
    logic               last_grant;
    logic [2*WIDTH-1:0] product;
    logic [1:0]         grant;

    simple_combinational_mult u_mult (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    // Grant only offered while idle; one-hot by construction.
    assign grant      = rr_grant(req0_valid, req1_valid, last_grant);
    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];
    assign busy       = (state != ST_IDLE);

    // Accept -> latch operands -> register product -> hold until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_a        <= '0;
            op_b        <= '0;
            id_r        <= 1'b0;
            last_grant  <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_product <= '0;
            op_count    <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_valid && req0_ready) begin
                        op_a       <= req0_a;
                        op_b       <= req0_b;
                        id_r       <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= ST_MUL;
                    end else if (req1_valid && req1_ready) begin
                        op_a       <= req1_a;
                        op_b       <= req1_b;
                        id_r       <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    rsp_product <= product;
                    rsp_id      <= id_r;
                    rsp_valid   <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed, table-driven bench for mult_share_arbiter.
module tb_mult_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_product;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v0;
        logic [15:0] a0;
        logic [15:0] b0;
        logic        v1;
        logic [15:0] a1;
        logic [15:0] b1;
        logic        exp_id;
        logic [31:0] exp_prod;
    } vec_t;

    vec_t vecs[9];

    mult_share_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready),
        .busy        (busy),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_idle_ready_never_both();
        chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
    endtask

    initial begin
        // {v0, a0, b0, v1, a1, b1, expected id, expected product}
        vecs[0] = '{1'b1, 16'd3,    16'd5,    1'b0, 16'd0,    16'd0,    1'b0, 32'h0000000F};
        vecs[1] = '{1'b1, 16'd2,    16'd7,    1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001};
        vecs[2] = '{1'b1, 16'd2,    16'd7,    1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'h0000000E};
        vecs[3] = '{1'b1, 16'd2,    16'd7,    1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001};
        vecs[4] = '{1'b1, 16'd2,    16'd7,    1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'h0000000E};
        vecs[5] = '{1'b0, 16'd9,    16'd9,    1'b1, 16'h1234, 16'h0010, 1'b1, 32'h00012340};
        vecs[6] = '{1'b0, 16'd0,    16'd0,    1'b1, 16'h0000, 16'hFFFF, 1'b1, 32'h00000000};
        vecs[7] = '{1'b1, 16'h8000, 16'd2,    1'b0, 16'd0,    16'd0,    1'b0, 32'h00010000};
        vecs[8] = '{1'b1, 16'hABCD, 16'd1,    1'b1, 16'h0100, 16'h0100, 1'b1, 32'h00010000};

        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready  = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id), 32'd0);
        chk("rst_rsp_prod",  rsp_product, 32'd0);
        chk("rst_op_count",  32'(op_count), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);

        // Reset asserted while an operation is in MUL discards it
        rst_n = 1'b1;
        req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h0010;
        #1;
        chk("rm_req1_ready", 32'(req1_ready), 32'd1);
        step();
        chk("rm_busy_mul", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req1_valid = 1'b0;
        step();
        chk("rm_busy",      32'(busy), 32'd0);
        chk("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rm_op_count",  32'(op_count), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rm_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Table: each operation from IDLE with rsp_ready=1, valids held throughout
        for (int i = 0; i < 9; i++) begin
            req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0;
            req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1;
            #1;
            chk("vec_req0_ready", 32'(req0_ready), 32'(vecs[i].exp_id == 1'b0));
            chk("vec_req1_ready", 32'(req1_ready), 32'(vecs[i].exp_id == 1'b1));
            chk_idle_ready_never_both();
            step();
            chk("vec_mul_busy",  32'(busy), 32'd1);
            chk("vec_mul_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("vec_mul_valid", 32'(rsp_valid), 32'd0);
            step();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("vec_rsp_id",    32'(rsp_id), 32'(vecs[i].exp_id));
            chk("vec_rsp_prod",  rsp_product, vecs[i].exp_prod);
            chk("vec_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
            step();
            chk("vec_done_valid", 32'(rsp_valid), 32'd0);
            chk("vec_op_count",   32'(op_count), 32'(i + 1));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: hold response for 10 cycles; pulses of valid in HOLD are ignored
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        #1;
        chk("bp_req0_ready", 32'(req0_ready), 32'd1);
        step();
        step();
        req0_valid = 1'b0;
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            req0_valid = (c == 3);
            req1_valid = (c == 5);
            req1_a = 16'd5; req1_b = 16'd5;
            #1;
            chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
            step();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_prod",  rsp_product, 32'hFFFE0001);
            chk("bp_id",    32'(rsp_id), 32'd0);
            chk("bp_busy",  32'(busy), 32'd1);
            chk("bp_count", 32'(op_count), 32'd9);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        step();
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_count", 32'(op_count), 32'd10);
        chk("bp_done_busy",  32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_no_extra", 32'({rsp_valid, busy}), 32'd0);
        end

        // Last grant was requester 0, so a tie now goes to requester 1
        req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd1;
        req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd4;
        #1;
        chk("lg_req0_ready", 32'(req0_ready), 32'd0);
        chk("lg_req1_ready", 32'(req1_ready), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("lg_drop_ready", 32'({req0_ready, req1_ready}), 32'd0);

        // op_count wrap from 0xFFFF
        step();
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
        step();
        req0_valid = 1'b0;
        step();
        chk("wrap_prod", rsp_product, 32'h0000000F);
        step();
        chk("wrap_count", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
